// File: rtl/mem_access_pkg.sv
// Shared types and width helpers for the memory access sequencer.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Beat-index width: clog2(max_beats), never narrower than one bit.
    function automatic int calc_len_w(input int max_beats);
        if (max_beats <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_beats);
        end
    endfunction

    // Width of a counter that must be able to hold max_val.
    function automatic int calc_cnt_w(input int max_val) ;
        if (max_val <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/mem_addr_step.sv
// Beat address generator: base + offset, either linear or confined to the
// 256-byte page of base (6502 indirect-vector wrap).
module mem_addr_step #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    input  logic              page_wrap,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] lin_s;
    logic [7:0]        low_s;

    // Select the linear sum or the page-confined sum
    always_comb begin
        lin_s = base + offset;
        low_s = base[7:0] + offset[7:0];
        if (page_wrap) begin
            addr = {base[ADDR_W-1:8], low_s};
        end else begin
            addr = lin_s;
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: runs one control-unit request as 1..MAX_BEATS byte
// beats on a ready-handshaked bus, with an optional per-beat timeout.
module mem_access_seq
    import mem_access_pkg::*;
#(
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BEATS = 2,
    parameter  int WAIT_MAX  = 15,
    localparam int LEN_W     = calc_len_w(MAX_BEATS)
) (
    input  logic                        clk_1,
    input  logic                        rst_n,
    input  logic                        req,
    input  logic                        w_rd,
    input  logic                        pc_data,
    input  logic [ADDR_W-1:0]           pc,
    input  logic [ADDR_W-1:0]           address,
    input  logic [LEN_W-1:0]            len,
    input  logic                        page_wrap,
    input  logic [DATA_W*MAX_BEATS-1:0] wdata,
    output logic [DATA_W*MAX_BEATS-1:0] rdata,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_rdy
);

    localparam int               WAIT_W  = calc_cnt_w(WAIT_MAX);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BEATS - 1);

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [ADDR_W-1:0]           base_r;
    logic [ADDR_W-1:0]           step_addr_s;
    logic                        w_rd_r;
    logic                        page_wrap_r;
    logic                        done_r;
    logic                        err_r;
    logic                        beat_ok_s;
    logic                        timeout_s;
    logic                        last_s;
    logic [LEN_W-1:0]            len_r;
    logic [LEN_W-1:0]            beat_r;
    logic [LEN_W-1:0]            len_clamp_s;
    logic [WAIT_W-1:0]           wait_r;
    logic [DATA_W*MAX_BEATS-1:0] wdata_r;
    logic [DATA_W*MAX_BEATS-1:0] rdata_r;

    // Requested length clamped to the number of data slots
    always_comb begin
        if (len > LEN_MAX) begin
            len_clamp_s = LEN_MAX;
        end else begin
            len_clamp_s = len;
        end
    end

    // FSM state register
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a ready beat takes priority over the timeout check
    always_comb begin
        state_nxt_s = state_r;
        beat_ok_s   = 1'b0;
        timeout_s   = 1'b0;
        last_s      = (beat_r == len_r);
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s = ST_BUS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (mem_rdy) begin
                    beat_ok_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_BUS;
                    end
                end else if ((WAIT_MAX > 32'sd0) && (wait_r == WAIT_W'(WAIT_MAX))) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request latch, beat/wait counters, read capture and completion pulses
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            base_r      <= '0;
            w_rd_r      <= 1'b0;
            len_r       <= '0;
            page_wrap_r <= 1'b0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            beat_r      <= '0;
            wait_r      <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        base_r      <= pc_data ? pc : address;
                        w_rd_r      <= w_rd;
                        len_r       <= len_clamp_s;
                        page_wrap_r <= page_wrap;
                        wdata_r     <= wdata;
                        rdata_r     <= '0;
                        beat_r      <= '0;
                        wait_r      <= '0;
                    end
                end
                ST_BUS: begin
                    if (beat_ok_s) begin
                        if (!w_rd_r) begin
                            rdata_r[int'(beat_r)*DATA_W +: DATA_W] <= mem_rdata;
                        end
                        wait_r <= '0;
                        if (last_s) begin
                            done_r <= 1'b1;
                        end else begin
                            beat_r <= beat_r + LEN_W'(1);
                        end
                    end else begin
                        wait_r <= wait_r + WAIT_W'(1);
                        if (timeout_s) begin
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    mem_addr_step #(
        .ADDR_W(ADDR_W)
    ) u_addr_step (
        .base     (base_r),
        .offset   (ADDR_W'(beat_r)),
        .page_wrap(page_wrap_r),
        .addr     (step_addr_s)
    );

    assign busy   = (state_r == ST_BUS);
    assign mem_en = busy;
    assign mem_we = busy & w_rd_r;
    assign done   = done_r;
    assign err    = err_r;
    assign rdata  = rdata_r;

    // Address and write data are driven only while a beat is on the bus
    always_comb begin
        if (busy) begin
            mem_addr  = step_addr_s;
            mem_wdata = wdata_r[int'(beat_r)*DATA_W +: DATA_W];
        end else begin
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq against a transaction-level model of
// beat addresses, data slots and completion timing.
module tb_mem_access_seq;

    localparam int WAIT_MAX  = 4;
    localparam int MAX_BEATS = 3;

    logic        clk_1 = 1'b0;
    logic        rst_n;
    logic        req, req0, w_rd, pc_data, page_wrap, mem_rdy, zero_rdy;
    logic [15:0] pc, address;
    logic [1:0]  len;
    logic [23:0] wdata;
    logic [7:0]  mem_rdata;
    logic [23:0] rdata, rdata0;
    logic        busy, done, err, mem_en, mem_we;
    logic        busy0, done0, err0, mem_en0, mem_we0;
    logic [15:0] mem_addr, mem_addr0;
    logic [7:0]  mem_wdata, mem_wdata0;

    int          checks = 0;
    int          failures = 0;
    int          wt_plan [3];
    logic [7:0]  rd_plan [3];
    logic [23:0] last_rdata;
    logic        done_seen;

    mem_access_seq #(.ADDR_W(16), .DATA_W(8), .MAX_BEATS(MAX_BEATS), .WAIT_MAX(WAIT_MAX)) dut (
        .clk_1(clk_1), .rst_n(rst_n), .req(req), .w_rd(w_rd), .pc_data(pc_data), .pc(pc),
        .address(address), .len(len), .page_wrap(page_wrap), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy));

    mem_access_seq #(.ADDR_W(16), .DATA_W(8), .MAX_BEATS(MAX_BEATS), .WAIT_MAX(0)) dut0 (
        .clk_1(clk_1), .rst_n(rst_n), .req(req0), .w_rd(w_rd), .pc_data(pc_data), .pc(pc),
        .address(address), .len(len), .page_wrap(page_wrap), .wdata(wdata), .rdata(rdata0),
        .busy(busy0), .done(done0), .err(err0), .mem_en(mem_en0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_rdy(zero_rdy));

    always #5 clk_1 = ~clk_1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] beat_addr(input logic [15:0] base, input int k, input logic pw);
        if (pw) return (base & 16'hFF00) | ((base + 16'(k)) & 16'h00FF);
        else    return base + 16'(k);
    endfunction

    // One access from accept to completion; called just after a rising edge.
    task automatic run_access(input logic wr, input logic pcd, input logic [15:0] pcv,
                              input logic [15:0] adv, input logic [1:0] lv, input logic pw,
                              input logic [23:0] wd);
        logic [15:0] base;
        logic [23:0] exp_rd;
        logic        to;
        int          nb, ncyc;
        base   = pcd ? pcv : adv;
        nb     = (int'(lv) >= MAX_BEATS) ? MAX_BEATS : int'(lv) + 1;
        exp_rd = 24'h0;
        to     = 1'b0;
        w_rd = wr; pc_data = pcd; pc = pcv; address = adv; len = lv; page_wrap = pw; wdata = wd;
        req = 1'b1; mem_rdy = 1'b0;
        @(negedge clk_1);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("rdata_hold", 32'(rdata), 32'(last_rdata));
        @(posedge clk_1); #1;
        req = 1'b0;
        pc = 16'($urandom); address = 16'($urandom); wdata = 24'($urandom); len = 2'($urandom);
        page_wrap = 1'($urandom); w_rd = 1'($urandom); pc_data = 1'($urandom);
        for (int k = 0; k < nb && !to; k++) begin
            to   = (wt_plan[k] > WAIT_MAX);
            ncyc = to ? WAIT_MAX + 1 : wt_plan[k] + 1;
            for (int c = 0; c < ncyc; c++) begin
                mem_rdy   = (!to && c == ncyc - 1);
                mem_rdata = mem_rdy ? rd_plan[k] : 8'($urandom);
                @(negedge clk_1);
                check_val("bus_en", 32'(mem_en), 32'd1);
                check_val("bus_busy", 32'(busy), 32'd1);
                check_val("bus_we", 32'(mem_we), 32'(wr));
                check_val("bus_addr", 32'(mem_addr), 32'(beat_addr(base, k, pw)));
                check_val("bus_wdata", 32'(mem_wdata), 32'((wd >> (8 * k)) & 24'hFF));
                check_val("bus_done", 32'(done), 32'd0);
                @(posedge clk_1); #1;
            end
            if (!to && !wr) exp_rd = exp_rd | (24'(rd_plan[k]) << (8 * k));
        end
        mem_rdy = 1'b0;
        req     = 1'b1;  // must be ignored in the completion cycle
        @(negedge clk_1);
        check_val("resp_done", 32'(done), 32'd1);
        check_val("resp_err", 32'(err), 32'(to));
        check_val("resp_busy", 32'(busy), 32'd0);
        check_val("resp_en", 32'(mem_en), 32'd0);
        check_val("resp_rdata", 32'(rdata), 32'(exp_rd));
        last_rdata = exp_rd;
        @(posedge clk_1); #1;
        req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req0 = 1'b0; w_rd = 1'b0; pc_data = 1'b0; page_wrap = 1'b0;
        mem_rdy = 1'b0; zero_rdy = 1'b0; pc = 16'h0; address = 16'h0; len = 2'd0;
        wdata = 24'h0; mem_rdata = 8'h0; last_rdata = 24'h0;
        repeat (2) @(posedge clk_1);
        @(negedge clk_1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_en", 32'(mem_en), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_wdata", 32'(mem_wdata), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        check_val("rst_dut0_ctl", 32'({rdata0, busy0, done0, err0, mem_en0, mem_we0}), 32'd0);
        check_val("rst_dut0_bus", 32'({mem_addr0, mem_wdata0}), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk_1);
            check_val("idle_en", 32'(mem_en), 32'd0);
        end
        @(posedge clk_1); #1;

        // single read, no wait
        wt_plan = '{0, 0, 0}; rd_plan = '{8'hA5, 8'h00, 8'h00};
        run_access(1'b0, 1'b1, 16'h1234, 16'h0000, 2'd0, 1'b0, 24'h0);
        // two-beat read across a page boundary, wrapped then linear
        rd_plan = '{8'h11, 8'h22, 8'h33};
        run_access(1'b0, 1'b0, 16'hAAAA, 16'h10FF, 2'd1, 1'b1, 24'h0);
        run_access(1'b0, 1'b0, 16'hAAAA, 16'h10FF, 2'd1, 1'b0, 24'h0);
        // write with three wait cycles per beat
        wt_plan = '{3, 3, 0};
        run_access(1'b1, 1'b0, 16'h0000, 16'h4000, 2'd1, 1'b0, 24'h00BEEF);
        // oversize length clamps to three beats, linear wrap at top of memory
        wt_plan = '{0, 1, 2}; rd_plan = '{8'hC1, 8'hC2, 8'hC3};
        run_access(1'b0, 1'b1, 16'hFFFE, 16'h0000, 2'd3, 1'b0, 24'h0);
        // timeout on the first beat, then on the second beat of a read
        wt_plan = '{9, 0, 0};
        run_access(1'b0, 1'b1, 16'h3000, 16'h0000, 2'd0, 1'b0, 24'h0);
        wt_plan = '{1, 9, 0}; rd_plan = '{8'h77, 8'h88, 8'h99};
        run_access(1'b0, 1'b0, 16'h0000, 16'h20FE, 2'd2, 1'b1, 24'h0);

        for (int i = 0; i < 40; i++) begin
            for (int b = 0; b < 3; b++) begin
                wt_plan[b] = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
                rd_plan[b] = 8'($urandom);
            end
            run_access(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                       1'($urandom), 24'($urandom));
        end

        // WAIT_MAX=0 never times out
        req0 = 1'b1;
        @(posedge clk_1); #1;
        req0 = 1'b0;
        repeat (40) @(posedge clk_1);
        @(negedge clk_1);
        check_val("nowait_busy", 32'(busy0), 32'd1);
        check_val("nowait_done", 32'(done0), 32'd0);
        @(posedge clk_1); #1;

        // reset in the middle of the second beat
        w_rd = 1'b0; pc_data = 1'b1; pc = 16'h2000; len = 2'd2; page_wrap = 1'b0;
        mem_rdy = 1'b1; mem_rdata = 8'h5A; req = 1'b1;
        @(posedge clk_1); #1;
        req = 1'b0;
        @(posedge clk_1); #1;
        mem_rdy = 1'b0;
        @(negedge clk_1);
        check_val("mid_addr", 32'(mem_addr), 32'h2001);
        check_val("mid_rdata", 32'(rdata), 32'h00005A);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_en", 32'(mem_en), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_addr", 32'(mem_addr), 32'd0);
        check_val("mid_rst_rdata", 32'(rdata), 32'd0);
        repeat (2) @(posedge clk_1);
        #1 rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge clk_1);
            done_seen = done_seen | done;
        end
        check_val("mid_rst_nodone", 32'(done_seen), 32'd0);
        check_val("mid_rst_idle", 32'(busy), 32'd0);
        @(posedge clk_1); #1;
        last_rdata = 24'h0;
        wt_plan = '{1, 0, 0}; rd_plan = '{8'h3C, 8'hC3, 8'h00};
        run_access(1'b0, 1'b0, 16'h0000, 16'h5555, 2'd1, 1'b1, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
